// File: rtl/observ_stepper.sv
// Push-button driven up/down stepper for the 5-bit observ selector.
// Buttons are synchronised, debounced and auto-repeated; every accepted step strobes step_pulse.
module observ_stepper #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_CYCLES   = 25_000_000,
   parameter int OBS_MAX         = 31
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       obs_load,
   input  logic [4:0] obs_load_val,
   output logic [4:0] observ,
   output logic       step_pulse,
   output logic       busy
);

   localparam int CNT_SPAN = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W    = (CNT_SPAN < 2) ? 1 : $clog2(CNT_SPAN);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
   localparam logic [4:0]       OBS_TOP  = 5'(OBS_MAX);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_DEBOUNCE = 3'd1;
   localparam logic [2:0] ST_FIRE     = 3'd2;
   localparam logic [2:0] ST_HOLD     = 3'd3;
   localparam logic [2:0] ST_RELEASE  = 3'd4;

   logic             up_meta, s_up;
   logic             down_meta, s_down;
   logic [2:0]       state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             dir_is_up, dir_is_up_d;
   logic             fire;

   logic dir_up, dir_down, dir_active, same_dir;
   logic [4:0] obs_inc, obs_dec, obs_step, load_clamped;

   // Two-flop synchronisers for the asynchronous board buttons.
   always_ff @(posedge clk) begin
      if (rst) begin
         up_meta   <= 1'b0;
         s_up      <= 1'b0;
         down_meta <= 1'b0;
         s_down    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep the two flops as a real pipeline;
         // blocking here would collapse the synchroniser into a single stage.
         up_meta   <= btn_up;
         s_up      <= up_meta;
         down_meta <= btn_down;
         s_down    <= down_meta;
      end
   end

   assign dir_up     = s_up & ~s_down;
   assign dir_down   = s_down & ~s_up;
   assign dir_active = dir_up | dir_down;
   assign same_dir   = dir_is_up ? dir_up : dir_down;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // through the case statement can infer a latch.
      state_d     = state;
      cnt_d       = cnt;
      dir_is_up_d = dir_is_up;
      fire        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (dir_active) begin
               dir_is_up_d = dir_up;
               cnt_d       = '0;
               state_d     = ST_DEBOUNCE;
            end
         end
         ST_DEBOUNCE: begin
            if (!same_dir) begin
               state_d = ST_IDLE;
            end else if (cnt == DEB_LAST) begin
               state_d = ST_FIRE;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         ST_FIRE: begin
            fire    = 1'b1;
            cnt_d   = '0;
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (!same_dir) begin
               cnt_d   = '0;
               state_d = ST_RELEASE;
            end else if ((REPEAT_CYCLES != 0) && (cnt == REP_LAST)) begin
               state_d = ST_FIRE;
            end else if (cnt != CNT_SAT) begin
               cnt_d = cnt + 1'b1;
            end
         end
         ST_RELEASE: begin
            // Any press, even a both-buttons chord, restarts the quiet period.
            if (s_up | s_down) begin
               cnt_d = '0;
            end else if (cnt == DEB_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         dir_is_up <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         dir_is_up <= dir_is_up_d;
      end
   end

   // Wrap arithmetic; >= guards keep the result inside 0..OBS_MAX.
   assign obs_inc      = (observ >= OBS_TOP) ? 5'd0 : observ + 5'd1;
   assign obs_dec      = (observ == 5'd0 || observ > OBS_TOP) ? OBS_TOP : observ - 5'd1;
   assign obs_step     = dir_is_up ? obs_inc : obs_dec;
   assign load_clamped = (obs_load_val > OBS_TOP) ? OBS_TOP : obs_load_val;

   // A load on the same edge as a FIRE step wins and the step is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         observ     <= 5'd0;
         step_pulse <= 1'b0;
      end else if (obs_load) begin
         observ     <= load_clamped;
         step_pulse <= 1'b0;
      end else if (fire) begin
         observ     <= obs_step;
         step_pulse <= 1'b1;
      end else begin
         step_pulse <= 1'b0;
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_observ_stepper.sv
// Directed bench for observ_stepper with short debounce/repeat times.
// Edges are counted from the first posedge that samples a new button level.
module tb_observ_stepper;

   localparam int DEB  = 4;
   localparam int REP  = 8;
   localparam int MAXV = 11;
   localparam int LAT  = DEB + 4;
   localparam int PER  = REP + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_up;
   logic       btn_down;
   logic       obs_load;
   logic [4:0] obs_load_val;
   logic [4:0] observ;
   logic       step_pulse;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;
   int edge_no;
   int pulses;
   int pulse_at[$];
   logic prev_pulse = 1'b0;

   observ_stepper #(
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_CYCLES  (REP),
      .OBS_MAX        (MAXV)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_up      (btn_up),
      .btn_down    (btn_down),
      .obs_load    (obs_load),
      .obs_load_val(obs_load_val),
      .observ      (observ),
      .step_pulse  (step_pulse),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n clock edges, sampling on the falling edge and logging step pulses.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         edge_no++;
         @(negedge clk);
         if (step_pulse === 1'b1) begin
            check($sformatf("no_back_to_back@%0d", edge_no), 32'(prev_pulse), 32'd0);
            pulses++;
            pulse_at.push_back(edge_no);
         end
         prev_pulse = step_pulse;
      end
   endtask

   task automatic start();
      edge_no = 0;
      pulses  = 0;
      pulse_at.delete();
   endtask

   function automatic int pulse_edge(input int k);
      return (pulse_at.size() > k) ? pulse_at[k] : -1;
   endfunction

   task automatic load(input logic [4:0] val);
      obs_load     = 1'b1;
      obs_load_val = val;
      run(1);
      obs_load     = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      btn_up       = 1'b0;
      btn_down     = 1'b0;
      obs_load     = 1'b0;
      obs_load_val = 5'd0;
      start();
      run(3);
      rst = 1'b0;
      check("reset_observ", 32'(observ), 32'd0);
      check("reset_step_pulse", 32'(step_pulse), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);

      // Single press: step at edge LAT, busy from edge 3.
      start();
      btn_up = 1'b1;
      run(2);
      check("t1_busy_edge2", 32'(busy), 32'd0);
      run(1);
      check("t1_busy_edge3", 32'(busy), 32'd1);
      run(9);
      btn_up = 1'b0;
      check("t1_pulses", 32'(pulses), 32'd1);
      check("t1_pulse_edge", 32'(pulse_edge(0)), 32'(LAT));
      check("t1_observ", 32'(observ), 32'd1);
      run(12);
      check("t1_idle_after_release", 32'(busy), 32'd0);

      // Short glitch never completes the debounce.
      rst = 1'b1;
      run(2);
      rst = 1'b0;
      start();
      btn_up = 1'b1;
      run(3);
      btn_up = 1'b0;
      run(1);
      check("t2_busy_during_glitch", 32'(busy), 32'd1);
      run(8);
      check("t2_pulses", 32'(pulses), 32'd0);
      check("t2_busy", 32'(busy), 32'd0);
      check("t2_observ", 32'(observ), 32'd0);

      // Long hold: first step at LAT, then every REP+1 cycles.
      start();
      btn_up = 1'b1;
      run(40);
      btn_up = 1'b0;
      check("t3_pulses", 32'(pulses), 32'd4);
      for (int k = 0; k < 4; k++)
         check($sformatf("t3_pulse_edge%0d", k), 32'(pulse_edge(k)), 32'(LAT + k * PER));
      check("t3_observ", 32'(observ), 32'd4);
      run(12);
      check("t3_idle", 32'(busy), 32'd0);

      // Both wrap directions.
      load(5'(MAXV));
      check("t4_load_observ", 32'(observ), 32'(MAXV));
      check("t4_load_no_pulse", 32'(step_pulse), 32'd0);
      start();
      btn_up = 1'b1;
      run(10);
      btn_up = 1'b0;
      run(12);
      check("t4_up_wrap_pulses", 32'(pulses), 32'd1);
      check("t4_up_wrap_observ", 32'(observ), 32'd0);
      start();
      btn_down = 1'b1;
      run(10);
      btn_down = 1'b0;
      run(12);
      check("t4_down_wrap_pulse_edge", 32'(pulse_edge(0)), 32'(LAT));
      check("t4_down_wrap_observ", 32'(observ), 32'(MAXV));

      // Chord is inactive; oversized load clamps.
      start();
      btn_up   = 1'b1;
      btn_down = 1'b1;
      run(20);
      check("t5_chord_pulses", 32'(pulses), 32'd0);
      check("t5_chord_busy", 32'(busy), 32'd0);
      check("t5_chord_observ", 32'(observ), 32'(MAXV));
      btn_up   = 1'b0;
      btn_down = 1'b0;
      run(4);
      load(5'd5);
      check("t5_load5", 32'(observ), 32'd5);
      load(5'd20);
      check("t5_load20_clamped", 32'(observ), 32'(MAXV));
      check("t5_load20_no_pulse", 32'(step_pulse), 32'd0);

      // Load coinciding with the FIRE step: load wins, step dropped.
      start();
      btn_up = 1'b1;
      run(LAT - 1);
      load(5'd7);
      check("t5_collide_observ", 32'(observ), 32'd7);
      check("t5_collide_pulses", 32'(pulses), 32'd0);
      check("t5_collide_busy", 32'(busy), 32'd1);
      run(2);
      btn_up = 1'b0;
      run(12);
      check("t5_collide_final_observ", 32'(observ), 32'd7);
      check("t5_collide_final_pulses", 32'(pulses), 32'd0);

      // Reset during HOLD with the button still held, then a fresh debounce.
      start();
      btn_up = 1'b1;
      run(12);
      check("t6_pre_reset_observ", 32'(observ), 32'd8);
      check("t6_pre_reset_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      run(2);
      check("t6_reset_observ", 32'(observ), 32'd0);
      check("t6_reset_busy", 32'(busy), 32'd0);
      check("t6_reset_step_pulse", 32'(step_pulse), 32'd0);
      rst = 1'b0;
      // Reset clears the synchronisers, so the full press latency applies again.
      start();
      run(1);
      check("t6_idle_after_reset", 32'(busy), 32'd0);
      run(11);
      check("t6_pulses", 32'(pulses), 32'd1);
      check("t6_pulse_edge", 32'(pulse_edge(0)), 32'(LAT));
      check("t6_observ", 32'(observ), 32'd1);
      btn_up = 1'b0;
      run(12);
      check("t6_final_busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
